// File: rtl/mem_resp.sv
`default_nettype none
// ============================================================================
// mem_resp : runs exec's 8/16-bit requests on an 8-bit SRAM/IO bus and returns
//            read data with a one-cycle mem_rdy completion pulse.
// Rev 1.0
// ============================================================================
module mem_resp #(
    parameter int MEM_WAIT = 1,
    parameter int IO_WAIT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [19:0] addr,
    input  logic [15:0] wr_data,
    input  logic        we,
    input  logic        m_io,
    input  logic        byteop,
    output logic [15:0] memout,
    output logic        mem_rdy,
    output logic [19:0] ext_addr,
    output logic [7:0]  ext_dout,
    input  logic [7:0]  ext_din,
    output logic        ext_rd,
    output logic        ext_wr,
    output logic        ext_io,
    input  logic        ext_wait
);

    localparam int               CNT_W     = 8;
    localparam logic [CNT_W-1:0] C_MEM_CNT = CNT_W'(MEM_WAIT);
    localparam logic [CNT_W-1:0] C_IO_CNT  = CNT_W'(IO_WAIT);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BYTE0 = 3'd1,
        GAP   = 3'd2,
        BYTE1 = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q;
    logic [19:0]      addr_q;
    logic [7:0]       wdata_hi_q;
    logic             we_q;
    logic             io_q;
    logic             byteop_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      memout_q;
    logic             mem_rdy_q;
    logic [19:0]      ext_addr_q;
    logic [7:0]       ext_dout_q;
    logic             ext_rd_q;
    logic             ext_wr_q;
    logic             ext_io_q;

    logic [19:0]      addr_hi_d;
    logic [CNT_W-1:0] reload_d;

    // IO space only carries a 16-bit port number, so its increment wraps at 64K.
    always_comb begin
        addr_hi_d = io_q ? {4'h0, addr_q[15:0] + 16'h0001} : addr_q + 20'h00001;
        reload_d  = io_q ? C_IO_CNT : C_MEM_CNT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_hi_q <= '0;
            we_q       <= 1'b0;
            io_q       <= 1'b0;
            byteop_q   <= 1'b0;
            cnt_q      <= '0;
            memout_q   <= '0;
            mem_rdy_q  <= 1'b0;
            ext_addr_q <= '0;
            ext_dout_q <= '0;
            ext_rd_q   <= 1'b0;
            ext_wr_q   <= 1'b0;
            ext_io_q   <= 1'b0;
        end else begin
            mem_rdy_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q     <= addr;
                        wdata_hi_q <= wr_data[15:8];
                        we_q       <= we;
                        io_q       <= m_io;
                        byteop_q   <= byteop;
                        cnt_q      <= m_io ? C_IO_CNT : C_MEM_CNT;
                        ext_addr_q <= m_io ? {4'h0, addr[15:0]} : addr;
                        ext_dout_q <= wr_data[7:0];
                        ext_rd_q   <= !we;
                        ext_wr_q   <= we;
                        ext_io_q   <= m_io;
                        state_q    <= BYTE0;
                    end
                end
                BYTE0, BYTE1: begin
                    // ext_wait freezes the counter, stretching the strobe.
                    if (!ext_wait) begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - C_ONE;
                        end else begin
                            ext_rd_q <= 1'b0;
                            ext_wr_q <= 1'b0;
                            if (!we_q) begin
                                if (state_q == BYTE0) begin
                                    memout_q <= byteop_q ? {8'h00, ext_din} : {memout_q[15:8], ext_din};
                                end else begin
                                    memout_q[15:8] <= ext_din;
                                end
                            end
                            if (state_q == BYTE1 || byteop_q) begin
                                ext_io_q  <= 1'b0;
                                mem_rdy_q <= 1'b1;
                                state_q   <= DONE;
                            end else begin
                                state_q <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    cnt_q      <= reload_d;
                    ext_addr_q <= addr_hi_d;
                    ext_dout_q <= wdata_hi_q;
                    ext_rd_q   <= !we_q;
                    ext_wr_q   <= we_q;
                    state_q    <= BYTE1;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign memout   = memout_q;
    assign mem_rdy  = mem_rdy_q;
    assign ext_addr = ext_addr_q;
    assign ext_dout = ext_dout_q;
    assign ext_rd   = ext_rd_q;
    assign ext_wr   = ext_wr_q;
    assign ext_io   = ext_io_q;

endmodule
`default_nettype wire
